// File: rtl/video_timing_pkg.sv
// Shared constants, axis region type and helpers for the video_timing raster generator.
package video_timing_pkg;

   localparam int unsigned DefHActive     = 640;
   localparam int unsigned DefHFrontPorch = 16;
   localparam int unsigned DefHSyncWidth  = 96;
   localparam int unsigned DefHBackPorch  = 48;
   localparam int unsigned DefVActive     = 480;
   localparam int unsigned DefVFrontPorch = 10;
   localparam int unsigned DefVSyncWidth  = 2;
   localparam int unsigned DefVBackPorch  = 33;

   typedef enum logic [1:0] {
      RegionActive,
      RegionFront,
      RegionSync,
      RegionBack
   } axis_region_e;

   function automatic axis_region_e axis_region(input int unsigned pos,
                                                input int unsigned active,
                                                input int unsigned front,
                                                input int unsigned sync);
      if (pos < active) return RegionActive;
      if (pos < active + front) return RegionFront;
      if (pos < active + front + sync) return RegionSync;
      return RegionBack;
   endfunction

   function automatic int unsigned count_width(input int unsigned total);
      return (total > 1) ? $clog2(total) : 1;
   endfunction

endpackage

// File: rtl/video_timing_axis.sv
// One raster axis: position counter with wrap, blank and sync flags registered from the next count.
module timing_axis
   import video_timing_pkg::*;
#(
   parameter int unsigned ACTIVE = DefHActive,
   parameter int unsigned FP     = DefHFrontPorch,
   parameter int unsigned SYNC   = DefHSyncWidth,
   parameter int unsigned BP     = DefHBackPorch,
   parameter bit          POL    = 1'b0,
   localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP,
   localparam int unsigned W     = count_width(TOTAL)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         step,
   output logic [W-1:0] count,
   output logic         last,
   output logic         blank,
   output logic         blank_next,
   output logic         sync
);

   localparam logic [W-1:0] LastPos = W'(TOTAL - 1);

   if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_param_check
      $error("timing_axis: every region length must be at least 1");
   end

   logic [W-1:0] count_q, count_d;
   logic         blank_q, sync_q;
   axis_region_e region_d;

   assign last = (count_q == LastPos);

   always_comb begin
      count_d = count_q;
      if (step) count_d = last ? '0 : count_q + W'(1);
      region_d   = axis_region(32'(count_d), ACTIVE, FP, SYNC);
      blank_next = (region_d != RegionActive);
   end

   // Reset parks on the final back-porch position so the first step lands on 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= LastPos;
         blank_q <= 1'b1;
         sync_q  <= ~POL;
      end else begin
         count_q <= count_d;
         blank_q <= blank_next;
         sync_q  <= (region_d == RegionSync) ? POL : ~POL;
      end
   end

   assign count = count_q;
   assign blank = blank_q;
   assign sync  = sync_q;

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: both axis counters, syncs, blanking, strobes and a frame counter.
// Optional VIDEO_TIMING_PIXEL_CE_EN adds a pix_ce port that qualifies every advance.
module video_timing
   import video_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE      = DefHActive,
   parameter int unsigned H_FRONT_PORCH = DefHFrontPorch,
   parameter int unsigned H_SYNC_WIDTH  = DefHSyncWidth,
   parameter int unsigned H_BACK_PORCH  = DefHBackPorch,
   parameter int unsigned V_ACTIVE      = DefVActive,
   parameter int unsigned V_FRONT_PORCH = DefVFrontPorch,
   parameter int unsigned V_SYNC_WIDTH  = DefVSyncWidth,
   parameter int unsigned V_BACK_PORCH  = DefVBackPorch,
   parameter bit          H_SYNC_POL    = 1'b0,
   parameter bit          V_SYNC_POL    = 1'b0,
   parameter int unsigned FRAME_W       = 8,
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH,
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH,
   localparam int unsigned H_W     = count_width(H_TOTAL),
   localparam int unsigned V_W     = count_width(V_TOTAL)
) (
   input  logic               clk_in,
   input  logic               reset,
   input  logic               en,
`ifdef VIDEO_TIMING_PIXEL_CE_EN
   input  logic               pix_ce,
`endif
   output logic [H_W-1:0]     h_count,
   output logic [V_W-1:0]     v_count,
   output logic               h_blank,
   output logic               v_blank,
   output logic               hsync,
   output logic               vsync,
   output logic               de,
   output logic               line_start,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_count
);

   logic adv, h_last, v_last, h_blank_next, v_blank_next, v_step;
   logic de_q, line_start_q, frame_start_q;
   logic [FRAME_W-1:0] frame_count_q;

`ifdef VIDEO_TIMING_PIXEL_CE_EN
   assign adv = en & pix_ce;
`else
   assign adv = en;
`endif

   assign v_step = adv & h_last;

   timing_axis #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FRONT_PORCH),
      .SYNC   (H_SYNC_WIDTH),
      .BP     (H_BACK_PORCH),
      .POL    (H_SYNC_POL)
   ) u_h_axis (
      .clk        (clk_in),
      .reset      (reset),
      .step       (adv),
      .count      (h_count),
      .last       (h_last),
      .blank      (h_blank),
      .blank_next (h_blank_next),
      .sync       (hsync)
   );

   timing_axis #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FRONT_PORCH),
      .SYNC   (V_SYNC_WIDTH),
      .BP     (V_BACK_PORCH),
      .POL    (V_SYNC_POL)
   ) u_v_axis (
      .clk        (clk_in),
      .reset      (reset),
      .step       (v_step),
      .count      (v_count),
      .last       (v_last),
      .blank      (v_blank),
      .blank_next (v_blank_next),
      .sync       (vsync)
   );

   // Strobes are set only on an advancing edge, so they self-clear after one clk_in cycle.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         de_q          <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_count_q <= '1;
      end else begin
         de_q          <= ~h_blank_next & ~v_blank_next;
         line_start_q  <= v_step;
         frame_start_q <= v_step & v_last;
         if (v_step & v_last) frame_count_q <= frame_count_q + FRAME_W'(1);
      end
   end

   assign de          = de_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign frame_count = frame_count_q;

endmodule

// File: doc/video_timing.md
# video_timing

Parametrised raster timing generator producing both horizontal and vertical timing from one clock. It generalises the line-count-only vertical sync stage into a single block: it owns both axis counters, has per-axis sync polarity, run/pause control, line/frame strobes and a frame counter. It sits between the pixel clock domain root and the pixel pipeline / VGA output pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT_PORCH, 16, pixels after active
- H_SYNC_WIDTH, 96, hsync pixels
- H_BACK_PORCH, 48, pixels after hsync
- V_ACTIVE, 480, visible lines
- V_FRONT_PORCH, 10, lines after active
- V_SYNC_WIDTH, 2, vsync lines
- V_BACK_PORCH, 33, lines after vsync
- H_SYNC_POL, 0, asserted level of hsync (0 = active-low)
- V_SYNC_POL, 0, asserted level of vsync
- FRAME_W, 8, frame counter width
- Derived: H_TOTAL/V_TOTAL = sum of axis params; H_W = $clog2(H_TOTAL), V_W = $clog2(V_TOTAL), min 1.

- clk_in  in  1  pixel/system clock
- reset  in  1  synchronous, active-high
- en  in  1  advance enable; low = hold all state
- pix_ce  in  1  pixel tick (only with VIDEO_TIMING_PIXEL_CE_EN)
- h_count  out  H_W  current pixel column
- v_count  out  V_W  current line
- h_blank / v_blank  out  1  count outside active region of that axis
- hsync / vsync  out  1  sync, polarity per *_SYNC_POL
- de  out  1  ~h_blank & ~v_blank
- line_start  out  1  one-clk pulse on entry to h_count = 0
- frame_start  out  1  one-clk pulse on entry to (0,0)
- frame_count  out  FRAME_W  frames started since reset

## Operation
- Advance condition adv = en (& pix_ce when macro defined).
- On adv: h_count increments; at H_TOTAL-1 wraps to 0 and v_count increments; v_count wraps at V_TOTAL-1 to 0.
- Axis regions in count order: active [0, ACTIVE), front porch, sync [ACTIVE+FP, ACTIVE+FP+SYNC), back porch.
- hsync asserted iff h_count in sync region; vsync asserted iff v_count in sync region (whole lines, changes only at h wrap).
- frame_count increments on each frame_start, wraps mod 2^FRAME_W.
- Reset state = last position of a frame: h_count = H_TOTAL-1, v_count = V_TOTAL-1, h_blank = v_blank = 1, de = 0, hsync = ~H_SYNC_POL, vsync = ~V_SYNC_POL, line_start = frame_start = 0, frame_count = all-ones. First adv therefore yields (0,0), both strobes, frame_count = 0.
- en low: counts, flags, frame_count hold; strobes forced 0 (never repeated while paused).
- reset dominates en/pix_ce; reset mid-frame returns to reset state on the next edge.

## Timing
- All outputs registered and mutually consistent: flags and strobes in a given cycle describe that cycle's h_count/v_count (decoded from next-state, no extra latency).
- Strobes are exactly one clk_in cycle wide regardless of pix_ce rate.
- Simultaneous h and v wrap: line_start and frame_start assert in the same cycle.

## Configuration
- VIDEO_TIMING_PIXEL_CE_EN defined: pix_ce port present; state advances only on cycles with en & pix_ce.
- Not defined: no pix_ce port; advances every cycle en is high.

## Structure
- Package video_timing_pkg: default 640x480@60 constants, axis region enum (ACTIVE, FRONT, SYNC, BACK).
- Sub-module timing_axis (params ACTIVE/FP/SYNC/BP/POL): counter, wrap flag, blank, sync; instantiated twice, vertical advanced by horizontal wrap.
- Elaboration check: every axis parameter >= 1.

## Test plan
Params H 8/1/2/1 (H_TOTAL 12), V 6/1/2/1 (V_TOTAL 10), polarities 0, FRAME_W 4.
- Hold reset 2 cycles -> h_count 11, v_count 9, de 0, hsync = vsync = 1, frame_count 15.
- Release reset, en = 1 -> next cycle h 0, v 0, line_start = frame_start = 1, de 1, frame_count 0; following cycle strobes 0.
- Free-run one line -> hsync low exactly at h 9 and 10; h_blank high h 8..11; line_start every 12 cycles.
- Free-run full frame -> vsync low for v 7..8 (24 cycles); frame_start every 120 cycles; frame_count wraps 15 -> 0 after 16 frames.
- Drop en at h 5 for 3 cycles -> counts hold at 5, no strobes; resumes at 6.
- Assert reset at (4,3) -> next cycle reset state. With macro, pix_ce every 4th cycle -> one advance per 4 clocks, strobes 1 clk wide.
